inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction ROM.
- Holds the PC, drives the ROM word address, and computes the next PC: sequential, branch or jump.
- Captures the combinational ROM output into an IF/ID register for the decode stage.
- Supports stall, flush and redirect; no branch delay slot (wrong-path fetch is squashed).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on a bubble.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- stall  input  1  hold PC and IF/ID contents (load-use hazard from decode).
- flush  input  1  squash IF/ID contents to a bubble (external kill).
- branch_taken  input  1  decode resolved a taken beq.
- branch_imm  input  16  beq immediate, word offset, signed.
- jump  input  1  decode holds a j instruction.
- jump_index  input  26  j instruction index field.
- rom_addr  output  32  byte address to ROM; always equals pc.
- rom_inst  input  32  combinational ROM data for rom_addr.
- if_pc  output  32  PC of the instruction held in IF/ID.
- if_pc_plus4  output  32  if_pc + 4.
- if_inst  output  32  instruction held in IF/ID.
- if_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_PC.
  - if_pc = 0, if_pc_plus4 = 0, if_inst = NOP_INST, if_valid = 0.
  - Any reset mid-operation discards all in-flight state immediately.
- ROM interface: rom_addr = pc, combinational. rom_inst is used in the same cycle (zero-latency ROM).
- Target arithmetic, always relative to the decode instruction (if_pc_plus4):
  - Branch target = if_pc_plus4 + (sign_extend(branch_imm) << 2), 32-bit modulo.
  - Jump target = {if_pc_plus4[31:28], jump_index, 2'b00}.
- redirect = jump | branch_taken. If both are asserted, jump wins.
- Per-cycle priority for pc:
  1. redirect: pc <= target.
  2. stall: pc holds.
  3. otherwise: pc <= pc + 4. Wraps 32'hFFFF_FFFC -> 0 with no flag.
- Per-cycle priority for IF/ID:
  1. redirect or flush: bubble (if_inst = NOP_INST, if_valid = 0; if_pc/if_pc_plus4 are loaded with the current pc/pc+4 for debug).
  2. stall: hold all IF/ID fields.
  3. otherwise: load rom_inst, pc, pc+4; if_valid = 1.
- Redirect overrides stall: a redirect while stalled still loads the target and inserts a bubble.
- flush together with stall: IF/ID becomes a bubble and pc holds.
- Latency:
  - Instruction at pc appears on if_inst one cycle after pc is presented.
  - A redirect costs exactly one bubble cycle.
- pc[1:0] is always 00. Targets are aligned by construction, so no alignment check is needed.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0 on rst_n.
  - fetch_cnt increments on every edge that loads a valid instruction into IF/ID.
  - bubble_cnt increments on every edge that inserts a bubble (redirect or flush).
  - Neither counter changes on stall-hold cycles.
  - Both wrap at 2^32.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (isa_pkg):
  - Opcode constants OP_BEQ 6'b000100 and OP_J 6'b000010.
  - NOP_INST, RESET_PC default, XLEN=32.
- Sub-module next_pc_calc (combinational):
  - Inputs: pc, if_pc_plus4, branch_imm, jump_index, branch_taken, jump, stall.
  - Outputs: next_pc, redirect.
- The top level holds the pc register, the IF/ID register and the optional counters.

Test Plan:
- Reset then run free with no control inputs:
  - rom_addr steps 0x00, 0x04, 0x08, ...
  - At the cycle after rom_addr = 0x04, if_inst = 32'h8c1f0000, if_pc = 0x04, if_valid = 1.
- Stall held 2 cycles with pc = 0x10:
  - rom_addr stays 0x10.
  - if_inst/if_pc unchanged for 2 cycles.
  - Resumes at 0x14 after stall drops.
- Branch with if_pc_plus4 = 0x38, branch_imm = 16'h0003, branch_taken = 1:
  - Next rom_addr = 0x44; one bubble (if_valid = 0).
  - Negative case: branch_imm = 16'hFFFE gives 0x30.
- Jump with if_pc_plus4 = 0x50, jump_index = 26'h000000f:
  - Next rom_addr = 0x3c.
  - Jump and branch asserted together: jump target wins.
- Simultaneous cases:
  - Redirect + stall: pc loads the target.
  - flush + stall: if_valid = 0, pc holds.
  - rst_n pulsed low mid-run: all outputs return to reset values asynchronously (before the next clk edge).
- FETCH_PERF_CNT_EN defined, 10 free-run cycles, 1 jump, 2 stall cycles:
  - fetch_cnt = 7, bubble_cnt = 1.
  - Wrap check: pc preloaded near 32'hFFFF_FFFC rolls to 0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants and helpers for the fetch slice.
package isa_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [XLEN-1:0] ISA_NOP      = 32'h0000_0000;
    localparam logic [XLEN-1:0] ISA_RESET_PC = 32'h0000_0000;

    // beq immediate is a signed word offset; convert to a signed byte offset
    function automatic logic signed [XLEN-1:0] branch_offset(input logic signed [15:0] imm);
        logic signed [XLEN-1:0] ext;
        ext = XLEN'(imm);
        return ext <<< 2;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump, taken branch, stall-hold or sequential.
module next_pc_calc
    import isa_pkg::*;
(
    input  logic [XLEN-1:0]        pc,
    input  logic [XLEN-1:0]        if_pc_plus4,
    input  logic signed [15:0]     branch_imm,
    input  logic [25:0]            jump_index,
    input  logic                   branch_taken,
    input  logic                   jump,
    input  logic                   stall,
    output logic [XLEN-1:0]        next_pc,
    output logic                   redirect
);

    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_jmp_tgt;

    // Both targets are relative to the instruction sitting in decode
    assign w_br_tgt  = if_pc_plus4 + $unsigned(branch_offset(branch_imm));
    assign w_jmp_tgt = {if_pc_plus4[31:28], jump_index, 2'b00};
    assign redirect  = jump | branch_taken;

    always_comb begin
        next_pc = pc + 32'd4;
        if (jump) begin
            next_pc = w_jmp_tgt;
        end else if (branch_taken) begin
            next_pc = w_br_tgt;
        end else if (stall) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, ROM addressing and IF/ID register.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module inst_fetch_unit
    import isa_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = ISA_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = ISA_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [15:0]     branch_imm,
    input  logic            jump,
    input  logic [25:0]     jump_index,
    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_inst,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [XLEN-1:0] if_inst,
    output logic            if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    logic [XLEN-1:0] r_pc_p0;
    logic [XLEN-1:0] r_if_pc_p1;
    logic [XLEN-1:0] r_if_pc_plus4_p1;
    logic [XLEN-1:0] r_if_inst_p1;
    logic            r_if_vld_p1;

    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_redirect;
    logic            w_bubble;
    logic            w_load;

    assign w_pc_plus4 = r_pc_p0 + 32'd4;
    assign w_bubble   = w_redirect | flush;
    assign w_load     = ~w_bubble & ~stall;

    next_pc_calc u_next_pc (
        .pc           (r_pc_p0),
        .if_pc_plus4  (r_if_pc_plus4_p1),
        .branch_imm   (branch_imm),
        .jump_index   (jump_index),
        .branch_taken (branch_taken),
        .jump         (jump),
        .stall        (stall),
        .next_pc      (w_next_pc),
        .redirect     (w_redirect)
    );

    // ---- p0 -> p1: PC update and IF/ID capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_p0          <= RESET_PC;
            r_if_pc_p1       <= '0;
            r_if_pc_plus4_p1 <= '0;
            r_if_inst_p1     <= NOP_INST;
            r_if_vld_p1      <= 1'b0;
        end else begin
            r_pc_p0 <= w_next_pc;
            // Bubbles still record the squashed fetch address for debug
            if (w_bubble) begin
                r_if_pc_p1       <= r_pc_p0;
                r_if_pc_plus4_p1 <= w_pc_plus4;
                r_if_inst_p1     <= NOP_INST;
                r_if_vld_p1      <= 1'b0;
            end else if (w_load) begin
                r_if_pc_p1       <= r_pc_p0;
                r_if_pc_plus4_p1 <= w_pc_plus4;
                r_if_inst_p1     <= rom_inst;
                r_if_vld_p1      <= 1'b1;
            end
        end
    end

    assign rom_addr    = r_pc_p0;
    assign if_pc       = r_if_pc_p1;
    assign if_pc_plus4 = r_if_pc_plus4_p1;
    assign if_inst     = r_if_inst_p1;
    assign if_valid    = r_if_vld_p1;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_load)   r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
